// File: rtl/name_writer_pkg.sv
// Shared constants, stride decode and fill-state type for the name RAM write port.
package name_writer_pkg;

  localparam int PTR_W = 13;

  localparam logic [2:0] REG_ADDR_LO = 3'd0;
  localparam logic [2:0] REG_ADDR_HI = 3'd1;
  localparam logic [2:0] REG_DATA    = 3'd2;
  localparam logic [2:0] REG_STRIDE  = 3'd3;
  localparam logic [2:0] REG_LEN_LO  = 3'd4;
  localparam logic [2:0] REG_LEN_HI  = 3'd5;
  localparam logic [2:0] REG_FILL    = 3'd6;
  localparam logic [2:0] REG_STATUS  = 3'd7;

  localparam logic [1:0] STRIDE_BYTE = 2'b00;
  localparam logic [1:0] STRIDE_CELL = 2'b01;
  localparam logic [1:0] STRIDE_ROW  = 2'b10;
  localparam logic [1:0] STRIDE_NONE = 2'b11;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_e;

  function automatic logic [PTR_W-1:0] stride_inc(input logic [1:0] code);
    logic [PTR_W-1:0] inc;
    case (code)
      STRIDE_BYTE: inc = 13'd1;
      STRIDE_CELL: inc = 13'd2;
      STRIDE_ROW:  inc = 13'd128;
      default:     inc = 13'd0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/name_writer_if.sv
// CPU register bus plus name RAM write port, bundled for the name writer.
interface name_writer_if;
  logic [2:0]  cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_write;
  logic        cpu_read;
  logic [7:0]  cpu_data_out;
  logic        busy;
  logic [12:0] write_addr;
  logic [7:0]  write_data;
  logic        write_enable;

  modport master (
    output cpu_addr, cpu_data_in, cpu_write, cpu_read,
    input  cpu_data_out, busy, write_addr, write_data, write_enable
  );

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_write, cpu_read,
    output cpu_data_out, busy, write_addr, write_data, write_enable
  );
endinterface

// File: rtl/name_writer_fill_seq.sv
// Fill sequencer: counts out a run of beats after a start pulse, one per clock.
module name_fill_seq
  import name_writer_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [PTR_W-1:0] len_i,
  output logic             busy_o,
  output logic             beat_o
);

  fill_state_e      state_q, state_d;
  logic [PTR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FILL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first beat fires in the start cycle so its registered write lands
  // in the first busy cycle; cnt_q then holds the beats still to issue.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_o  = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (start_i && (len_i != '0)) begin
          beat_o  = 1'b1;
          cnt_d   = len_i - 13'd1;
          state_d = FILL_RUN;
        end
      end
      FILL_RUN: begin
        if (cnt_q != '0) begin
          beat_o = 1'b1;
          cnt_d  = cnt_q - 13'd1;
        end else begin
          state_d = FILL_IDLE;
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  assign busy_o = (state_q == FILL_RUN);

endmodule

// File: rtl/name_writer.sv
// CPU-side name RAM write port: pointer/stride registers, single writes and fill engine.
module name_writer
  import name_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  name_writer_if.slave bus
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [1:0]       stride_q, stride_d;
  logic [PTR_W-1:0] len_q, len_d;
  logic [7:0]       fill_q, fill_d;
  logic             rej_q, rej_d;
  logic [7:0]       rd_q, rd_d;
  logic [PTR_W-1:0] waddr_q, waddr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             we_q, we_d;

  logic       busy, beat;
  logic       wr_ok, start, data_wr;
  logic [7:0] rd_val;

  assign wr_ok   = bus.cpu_write && !busy;
  assign start   = wr_ok && (bus.cpu_addr == REG_FILL);
  assign data_wr = wr_ok && (bus.cpu_addr == REG_DATA);

  name_fill_seq u_fill (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (start),
    .len_i   (len_q),
    .busy_o  (busy),
    .beat_o  (beat)
  );

  always_comb begin
    rd_val = 8'h00;
    case (bus.cpu_addr)
      REG_ADDR_LO: rd_val = ptr_q[7:0];
      REG_ADDR_HI: rd_val = {3'b000, ptr_q[12:8]};
      REG_STRIDE:  rd_val = {6'b0, stride_q};
      REG_LEN_LO:  rd_val = len_q[7:0];
      REG_LEN_HI:  rd_val = {3'b000, len_q[12:8]};
      REG_STATUS:  rd_val = {6'b0, rej_q, busy};
      default:     rd_val = 8'h00;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    stride_d = stride_q;
    len_d    = len_q;
    fill_d   = fill_q;
    rej_d    = rej_q;
    rd_d     = rd_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;

    // A reject arriving with a STATUS read survives the clear.
    if (bus.cpu_read) begin
      rd_d = rd_val;
      if (bus.cpu_addr == REG_STATUS) rej_d = 1'b0;
    end
    if (bus.cpu_write && busy) rej_d = 1'b1;

    if (wr_ok) begin
      case (bus.cpu_addr)
        REG_ADDR_LO: ptr_d[7:0]  = bus.cpu_data_in;
        REG_ADDR_HI: ptr_d[12:8] = bus.cpu_data_in[4:0];
        REG_STRIDE:  stride_d    = bus.cpu_data_in[1:0];
        REG_LEN_LO:  len_d[7:0]  = bus.cpu_data_in;
        REG_LEN_HI:  len_d[12:8] = bus.cpu_data_in[4:0];
        REG_FILL:    fill_d      = bus.cpu_data_in;
        default: ;
      endcase
    end

    // The start beat takes its byte straight off the bus; fill_q is not loaded yet.
    if (data_wr || beat) begin
      we_d    = 1'b1;
      waddr_d = ptr_q;
      wdata_d = (data_wr || start) ? bus.cpu_data_in : fill_q;
      ptr_d   = ptr_q + stride_inc(stride_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q    <= '0;
      stride_q <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      rej_q    <= 1'b0;
      rd_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      rej_q    <= rej_d;
      rd_q     <= rd_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
    end
  end

  assign bus.cpu_data_out = rd_q;
  assign bus.busy         = busy;
  assign bus.write_addr   = waddr_q;
  assign bus.write_data   = wdata_q;
  assign bus.write_enable = we_q;

endmodule
